dac_multi_ch: RTL and testbench

//  Parametrised multi-channel successor of the single 12-bit DAC model for the sine-wave path.

---
 rtl/dac_pkg.sv | 26 ++
 rtl/dac_channel.sv | 95 +++++++++
 rtl/dac_multi_ch.sv | 140 ++++++++++++++
 tb/tb_dac_multi_ch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// ============================================================================
// Module   : dac_pkg
// Purpose  : Shared types and helpers for the multi-channel DAC model:
//            FSM state encoding, channel-index width function, channel limit.
// Config   : DAC_SLEW_LIMIT_EN (used by dac_channel / dac_multi_ch)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_pkg;

    localparam int MAX_NUM_CH = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } dac_state_t;

    // Channel-select width: clog2 of the channel count, never below one bit.
    function automatic int dac_ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_channel.sv
// ============================================================================
// Module   : dac_channel
// Purpose  : One DAC channel: shadow register with dirty flag, transfer
//            target, output code (optionally slew limited) and a real-valued
//            analog output model.
// Config   : DAC_SLEW_LIMIT_EN - code walks toward target by at most
//            SLEW_STEP per en tick; otherwise code follows target directly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_channel #(
    parameter int  WIDTH     = 12,
    parameter real VREF      = 3.3,
    parameter int  SLEW_STEP = 64
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DAC_SLEW_LIMIT_EN
    input  logic             en,
`endif
    input  logic             xfer,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             dirty,
    output logic             slewing,
    output logic [WIDTH-1:0] code
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_target;
    logic             r_dirty;

    // Shadow capture and transfer; a write on a transfer edge stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_target <= '0;
            r_dirty  <= 1'b0;
        end else begin
            if (xfer && r_dirty) begin
                r_target <= r_shadow;
                r_dirty  <= 1'b0;
            end
            if (wr_en) begin
                r_shadow <= wr_data;
                r_dirty  <= 1'b1;
            end
        end
    end

`ifdef DAC_SLEW_LIMIT_EN
    logic [WIDTH-1:0] r_code;
    logic [WIDTH-1:0] w_code_nxt;
    logic [31:0]      w_step;
    logic [31:0]      w_up;
    logic [31:0]      w_dn;

    // Next code: one bounded step toward target, landing exactly on it.
    always_comb begin
        w_step     = 32'(SLEW_STEP);
        w_up       = 32'(r_target) - 32'(r_code);
        w_dn       = 32'(r_code) - 32'(r_target);
        w_code_nxt = r_code;
        if (r_target > r_code) begin
            w_code_nxt = (w_up > w_step) ? WIDTH'(32'(r_code) + w_step) : r_target;
        end else if (r_target < r_code) begin
            w_code_nxt = (w_dn > w_step) ? WIDTH'(32'(r_code) - w_step) : r_target;
        end
    end

    // Output code advances only on update ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= '0;
        end else if (en) begin
            r_code <= w_code_nxt;
        end
    end

    assign code = r_code;
`else
    assign code = r_target;
`endif

    assign dirty   = r_dirty;
    assign slewing = (code != r_target);

    // Simulation-only analog view of the output code.
    real a_out;
    always_comb a_out = real'(code) * VREF / real'((2 ** WIDTH) - 1);

endmodule

`default_nettype wire

// File: rtl/dac_multi_ch.sv
// ============================================================================
// Module   : dac_multi_ch
// Purpose  : Multi-channel DAC front end. Valid/ready write port into
//            per-channel shadows; immediate per-tick or commit-gated (LDAC
//            style) transfer to outputs; sticky overrun / bad-channel flags.
// Config   : DAC_SLEW_LIMIT_EN - slew-limited output codes per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_multi_ch
    import dac_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  WIDTH     = 12,
    parameter real VREF      = 3.3,
    parameter int  SLEW_STEP = 64,
    localparam int CH_W      = dac_ch_w(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    sync_mode,
    input  logic                    commit,
    input  logic                    clr_err,
    output logic [NUM_CH*WIDTH-1:0] dac_code,
    output logic                    busy,
    output logic                    overrun,
    output logic                    bad_ch
);

    dac_state_t       r_state;
    dac_state_t       w_state_nxt;
    logic             w_xfer;
    logic             w_accept;
    logic             w_ch_ok;
    logic [31:0]      w_ch_idx;
    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_dirty;
    logic [NUM_CH-1:0] w_slewing;
    logic             w_ovr_set;
    logic             r_overrun;
    logic             r_bad_ch;

    assign wr_ready = (r_state == ST_IDLE);
    assign w_accept = wr_valid && wr_ready;
    assign w_ch_idx = 32'(wr_ch);
    assign w_ch_ok  = (w_ch_idx < 32'(NUM_CH));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer decision; sync_mode only matters while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!sync_mode) begin
                    w_xfer = en;
                end else if (commit) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (en) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // An overwrite only loses data if the old shadow is not leaving on this edge.
    assign w_ovr_set = |(w_wr_en & w_dirty) && !w_xfer;

    // Sticky error flags; clearing takes priority over a simultaneous set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_bad_ch  <= 1'b0;
        end else if (clr_err) begin
            r_overrun <= 1'b0;
            r_bad_ch  <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_accept && !w_ch_ok) begin
                r_bad_ch <= 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [WIDTH-1:0] w_code;

            assign w_wr_en[k] = w_accept && w_ch_ok && (w_ch_idx == 32'(k));

            dac_channel #(
                .WIDTH     (WIDTH),
                .VREF      (VREF),
                .SLEW_STEP (SLEW_STEP)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
`ifdef DAC_SLEW_LIMIT_EN
                .en      (en),
`endif
                .xfer    (w_xfer),
                .wr_en   (w_wr_en[k]),
                .wr_data (wr_data),
                .dirty   (w_dirty[k]),
                .slewing (w_slewing[k]),
                .code    (w_code)
            );

            assign dac_code[k*WIDTH +: WIDTH] = w_code;
        end
    endgenerate

    assign busy    = (|w_dirty) || (r_state == ST_ARMED) || (|w_slewing);
    assign overrun = r_overrun;
    assign bad_ch  = r_bad_ch;

endmodule

`default_nettype wire

// File: tb/tb_dac_multi_ch.sv
// ============================================================================
// Module   : tb_dac_multi_ch
// Purpose  : Self-checking bench for dac_multi_ch: directed scenarios plus a
//            randomized run against a behavioural model of the channel rules.
// Config   : DAC_SLEW_LIMIT_EN selects the slew-limited model and scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_multi_ch;

    localparam int NUM_CH    = 4;
    localparam int WIDTH     = 12;
    localparam int SLEW_STEP = 64;
    localparam int CH_W      = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, wr_valid = 1'b0, sync_mode = 1'b0, commit = 1'b0, clr_err = 1'b0;
    logic [CH_W-1:0]         wr_ch = '0;
    logic [WIDTH-1:0]        wr_data = '0;
    logic                    wr_ready, busy, overrun, bad_ch;
    logic [NUM_CH*WIDTH-1:0] dac_code;

    // Second instance with a non-power-of-two channel count to reach bad_ch.
    logic b_en = 1'b0, b_wr_valid = 1'b0, b_clr_err = 1'b0;
    logic [1:0]      b_wr_ch = '0;
    logic [WIDTH-1:0] b_wr_data = '0;
    logic            b_wr_ready, b_busy, b_overrun, b_bad_ch;
    logic [3*WIDTH-1:0] b_dac_code;

    int total = 0;
    int bad   = 0;

    int m_shadow [NUM_CH];
    int m_target [NUM_CH];
    int m_code   [NUM_CH];
    bit m_dirty  [NUM_CH];
    bit m_armed, m_ovr, m_bad;

    always #5 clk = ~clk;

    dac_multi_ch #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .VREF(3.3), .SLEW_STEP(SLEW_STEP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_data(wr_data), .sync_mode(sync_mode), .commit(commit),
        .clr_err(clr_err), .dac_code(dac_code), .busy(busy), .overrun(overrun), .bad_ch(bad_ch)
    );

    dac_multi_ch #(.NUM_CH(3), .WIDTH(WIDTH), .VREF(3.3), .SLEW_STEP(SLEW_STEP)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(b_en), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_ch(b_wr_ch), .wr_data(b_wr_data), .sync_mode(1'b0), .commit(1'b0),
        .clr_err(b_clr_err), .dac_code(b_dac_code), .busy(b_busy), .overrun(b_overrun), .bad_ch(b_bad_ch)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = 0; m_target[k] = 0; m_code[k] = 0; m_dirty[k] = 0;
        end
        m_armed = 0; m_ovr = 0; m_bad = 0;
    endtask

    // Apply the channel rules for one rising edge using the inputs now applied.
    task automatic model_edge();
        bit acc, ok, xfer, pre_dirty;
        int ch, d;
        acc  = wr_valid && !m_armed;
        ch   = int'(wr_ch);
        ok   = ch < NUM_CH;
        pre_dirty = ok ? m_dirty[ch] : 1'b0;
        xfer = 0;
        if (!m_armed) begin
            if (!sync_mode) xfer = en;
            else if (commit) m_armed = 1;
        end else if (en) begin
            xfer = 1; m_armed = 0;
        end
`ifdef DAC_SLEW_LIMIT_EN
        if (en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                d = m_target[k] - m_code[k];
                if (d > SLEW_STEP) d = SLEW_STEP;
                if (d < -SLEW_STEP) d = -SLEW_STEP;
                m_code[k] += d;
            end
        end
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            if (xfer && m_dirty[k]) begin
                m_target[k] = m_shadow[k];
                m_dirty[k]  = 0;
            end
`ifndef DAC_SLEW_LIMIT_EN
            m_code[k] = m_target[k];
`endif
        end
        if (clr_err) begin
            m_ovr = 0; m_bad = 0;
        end else begin
            if (acc && ok && pre_dirty && !xfer) m_ovr = 1;
            if (acc && !ok) m_bad = 1;
        end
        if (acc && ok) begin
            m_shadow[ch] = int'(wr_data);
            m_dirty[ch]  = 1;
        end
    endtask

    function automatic bit model_busy();
        bit b = m_armed;
        for (int k = 0; k < NUM_CH; k++)
            if (m_dirty[k] || m_code[k] != m_target[k]) b = 1;
        return b;
    endfunction

    function automatic int code_of(input int k);
        return int'(dac_code[k*WIDTH +: WIDTH]);
    endfunction

    task automatic compare_all();
        for (int k = 0; k < NUM_CH; k++)
            check($sformatf("code%0d", k), 64'(code_of(k)), 64'(m_code[k]));
        check("wr_ready", 64'(wr_ready), 64'(!m_armed));
        check("busy", 64'(busy), 64'(model_busy()));
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("bad_ch", 64'(bad_ch), 64'(m_bad));
    endtask

    // One clock: model follows the edge, outputs checked 1 ns later, pulses dropped.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        en = 0; wr_valid = 0; commit = 0; clr_err = 0;
        b_en = 0; b_wr_valid = 0; b_clr_err = 0;
    endtask

    task automatic write(input int ch, input int data);
        wr_valid = 1; wr_ch = CH_W'(ch); wr_data = WIDTH'(data);
        cycle();
    endtask

    task automatic tick();
        en = 1;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        real v;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("b_reset_code", 64'(b_dac_code), 64'd0);
        rst_n = 1;

        // Immediate mode: write mid-period, appears on next tick only.
        sync_mode = 0;
        idle(3);
        write(2, 4000);
        idle(5);
        check("t1_before_tick", 64'(code_of(2)), 64'd0);
`ifdef DAC_SLEW_LIMIT_EN
        tick();
        idle(2);
`else
        tick();
        check("t1_code2", 64'(code_of(2)), 64'd4000);
        v = dut.g_ch[2].u_ch.a_out;
        check("t1_aout", 64'((v > 3.2224) && (v < 3.2244)), 64'd1);
`endif

        // Commit-gated transfer: both codes change together on the en edge.
        sync_mode = 1;
        write(0, 1000);
        write(1, 500);
        commit = 1;
        cycle();
        check("t2_ready_armed", 64'(wr_ready), 64'd0);
        idle(298);
        check("t2_hold_ch0", 64'(code_of(0)), 64'(m_code[0]));
        tick();
`ifndef DAC_SLEW_LIMIT_EN
        check("t2_code0", 64'(code_of(0)), 64'd1000);
        check("t2_code1", 64'(code_of(1)), 64'd500);
`endif
        check("t2_ready_idle", 64'(wr_ready), 64'd1);

        // Overrun: second write to a pending channel wins and sets the flag.
        sync_mode = 0;
        write(1, 100);
        write(1, 200);
        check("t3_overrun", 64'(overrun), 64'd1);
        tick();
`ifndef DAC_SLEW_LIMIT_EN
        check("t3_code1", 64'(code_of(1)), 64'd200);
`endif
        clr_err = 1;
        cycle();
        check("t3_cleared", 64'(overrun), 64'd0);

        // Write on the tick edge is held until the following tick.
        wr_valid = 1; wr_ch = 2'd3; wr_data = 12'd77; en = 1;
        cycle();
        check("t4_same_edge", 64'(code_of(3)), 64'd0);
        idle(3);
        tick();
`ifndef DAC_SLEW_LIMIT_EN
        check("t4_code3", 64'(code_of(3)), 64'd77);
`endif

        // Out-of-range channel on the three-channel instance.
        b_wr_valid = 1; b_wr_ch = 2'd3; b_wr_data = 12'd555; b_en = 1;
        cycle();
        b_en = 1;
        cycle();
        check("t4_bad_ch", 64'(b_bad_ch), 64'd1);
        check("t4_bad_code", 64'(b_dac_code), 64'd0);
        check("t4_bad_busy", 64'(b_busy), 64'd0);
        b_clr_err = 1;
        cycle();
        check("t4_bad_clr", 64'(b_bad_ch), 64'd0);

        // Asynchronous reset while armed with a pending channel.
        sync_mode = 1;
        write(0, 123);
        commit = 1;
        cycle();
        check("t5_armed", 64'(wr_ready), 64'd0);
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 rst_n = 1;
        sync_mode = 0;
        tick();
        check("t5_after_en", 64'(code_of(0)), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);

`ifdef DAC_SLEW_LIMIT_EN
        // Slew limit: 0 -> 200 in steps of 64 over four ticks after transfer.
        write(0, 200);
        tick();
        tick(); check("t6_s1", 64'(code_of(0)), 64'd64);
        tick(); check("t6_s2", 64'(code_of(0)), 64'd128);
        tick(); check("t6_s3", 64'(code_of(0)), 64'd192);
        check("t6_busy_mid", 64'(busy), 64'd1);
        tick(); check("t6_s4", 64'(code_of(0)), 64'd200);
        check("t6_busy_end", 64'(busy), 64'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) sync_mode = ~sync_mode;
            wr_valid = ($urandom_range(0, 9) < 4);
            wr_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            wr_data  = WIDTH'($urandom);
            en       = ($urandom_range(0, 6) == 0);
            commit   = ($urandom_range(0, 9) == 0);
            clr_err  = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
